digi_ota_seq: RTL and testbench

Sequencer for the inverter-based digital OTA/comparator cell. After reset it runs a one-shot auto-zero phase and a SAR offset-trim calibration. It then loops continuously: auto-zero, settle, majority-vote sample, power-down. It sits between the tt_um top-level pins and the OTA cell and drives the cell's enable, auto-zero and trim controls.

---
 rtl/digi_ota_pkg.sv | 25 ++
 rtl/digi_ota_seq_if.sv | 23 ++
 rtl/digi_ota_sync2.sv | 19 +
 rtl/digi_ota_seq.sv | 165 ++++++++++++++++
 tb/tb_digi_ota_seq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/digi_ota_pkg.sv
// rtl/digi_ota_pkg.sv - shared types and defaults for the digital OTA sequencer
package digi_ota_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL_AZ,
    ST_CAL_BIT,
    ST_RUN_AZ,
    ST_RUN_SETTLE,
    ST_RUN_SAMPLE,
    ST_RUN_OFF
  } state_t;

  localparam int DEF_TRIM_W     = 4;
  localparam int DEF_AZ_CYC     = 8;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_VOTE_N     = 3;
  localparam int DEF_PERIOD     = 32;

  // Midscale trim: MSB set, all other bits clear.
  function automatic logic [31:0] trim_mid(input int w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/digi_ota_seq_if.sv
// rtl/digi_ota_seq_if.sv - pin-side control/status bundle between tt_um top and OTA sequencer
interface digi_ota_seq_if #(parameter int TRIM_W = 4);
  logic              ena;
  logic              start_cal;
  logic              cmp_in;
  logic              ota_en;
  logic              az_en;
  logic [TRIM_W-1:0] trim;
  logic              sample;
  logic              sample_valid;
  logic              cal_done;
  logic              busy;

  modport master (
    output ena, start_cal, cmp_in,
    input  ota_en, az_en, trim, sample, sample_valid, cal_done, busy
  );

  modport slave (
    input  ena, start_cal, cmp_in,
    output ota_en, az_en, trim, sample, sample_valid, cal_done, busy
  );
endinterface

// File: rtl/digi_ota_sync2.sv
// rtl/digi_ota_sync2.sv - two-flop synchroniser, async active-low reset to 0
module digi_ota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/digi_ota_seq.sv
// rtl/digi_ota_seq.sv - OTA sequencer: auto-zero + SAR trim calibration, then periodic
// auto-zero / settle / majority-vote sample / power-down loop
module digi_ota_seq
  import digi_ota_pkg::*;
#(
  parameter int TRIM_W     = DEF_TRIM_W,
  parameter int AZ_CYC     = DEF_AZ_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int VOTE_N     = DEF_VOTE_N,
  parameter int PERIOD     = DEF_PERIOD
) (
  input  logic           clk,
  input  logic           rst_n,
  digi_ota_seq_if.slave  bus
);
  localparam int CNT_W  = $clog2(PERIOD + 1);
  localparam int BIT_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int VOTE_W = $clog2(VOTE_N + 1);

  localparam logic [TRIM_W-1:0] MID        = TRIM_W'(trim_mid(TRIM_W));
  localparam logic [CNT_W-1:0]  AZ_LAST    = CNT_W'(AZ_CYC - 1);
  localparam logic [CNT_W-1:0]  SET_LAST   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(AZ_CYC + SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  VOTE_END   = CNT_W'(AZ_CYC + SETTLE_CYC + VOTE_N);
  localparam logic [CNT_W-1:0]  PER_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [VOTE_W-1:0] VOTE_HALF  = VOTE_W'(VOTE_N / 2);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [VOTE_W-1:0] votes;
  logic [TRIM_W-1:0] trim;
  logic              ota_en, az_en, sample, sample_valid, cal_done, busy;
  logic              cmp_s;
  logic              cal_req;

  digi_ota_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.cmp_in),
    .q     (cmp_s)
  );

  // start_cal is ignored while a calibration is already running
  assign cal_req = (bus.start_cal && state != ST_CAL_AZ && state != ST_CAL_BIT) ||
                   (state == ST_IDLE && !cal_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      votes        <= '0;
      trim         <= MID;
      ota_en       <= 1'b0;
      az_en        <= 1'b0;
      sample       <= 1'b0;
      sample_valid <= 1'b0;
      cal_done     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!bus.ena) begin
        state  <= ST_IDLE;
        ota_en <= 1'b0;
        az_en  <= 1'b0;
        busy   <= 1'b0;
        if (bus.start_cal) cal_done <= 1'b0;
      end else if (cal_req) begin
        state    <= ST_CAL_AZ;
        cnt      <= '0;
        trim     <= MID;
        cal_done <= 1'b0;
        ota_en   <= 1'b1;
        az_en    <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_RUN_AZ;
            cnt    <= '0;
            ota_en <= 1'b1;
            az_en  <= 1'b1;
            busy   <= 1'b1;
          end
          ST_CAL_AZ: begin
            if (cnt == AZ_LAST) begin
              state                <= ST_CAL_BIT;
              cnt                  <= '0;
              bit_idx              <= BIT_W'(TRIM_W - 1);
              trim[TRIM_W-1]       <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CAL_BIT: begin
            if (cnt == SET_LAST) begin
              cnt           <= '0;
              trim[bit_idx] <= cmp_s;
              if (bit_idx == '0) begin
                state    <= ST_RUN_AZ;
                cal_done <= 1'b1;
              end else begin
                bit_idx                    <= bit_idx - BIT_W'(1);
                trim[bit_idx - BIT_W'(1)]  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN_AZ: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == AZ_LAST) begin
              state <= ST_RUN_SETTLE;
              az_en <= 1'b0;
            end
          end
          ST_RUN_SETTLE: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == SETTLE_END) begin
              state <= ST_RUN_SAMPLE;
              votes <= '0;
            end
          end
          ST_RUN_SAMPLE: begin
            // VOTE_N counting cycles, then one cycle to publish the vote
            cnt <= cnt + CNT_W'(1);
            if (cnt == VOTE_END) begin
              state        <= ST_RUN_OFF;
              sample       <= (votes > VOTE_HALF);
              sample_valid <= 1'b1;
              ota_en       <= 1'b0;
            end else begin
              votes <= votes + VOTE_W'(cmp_s);
            end
          end
          ST_RUN_OFF: begin
            if (cnt == PER_LAST) begin
              state  <= ST_RUN_AZ;
              cnt    <= '0;
              ota_en <= 1'b1;
              az_en  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= ST_IDLE;
            ota_en <= 1'b0;
            az_en  <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ota_en       = ota_en;
  assign bus.az_en        = az_en;
  assign bus.trim         = trim;
  assign bus.sample       = sample;
  assign bus.sample_valid = sample_valid;
  assign bus.cal_done     = cal_done;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_digi_ota_seq.sv
// tb/tb_digi_ota_seq.sv - self-checking bench for digi_ota_seq with a time-based behavioural model
module tb_digi_ota_seq;
  localparam int TW  = 4;
  localparam int AZ  = 8;
  localparam int SET = 4;
  localparam int VN  = 3;
  localparam int PER = 32;
  localparam int M_IDLE = 0, M_CAL = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  digi_ota_seq_if #(.TRIM_W(TW)) bus ();

  digi_ota_seq #(
    .TRIM_W(TW), .AZ_CYC(AZ), .SETTLE_CYC(SET), .VOTE_N(VN), .PERIOD(PER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: mode + cycles elapsed in that mode; outputs follow by arithmetic.
  int          m_mode = M_IDLE;
  int          m_t = 0;
  logic [TW-1:0] m_trim = 4'b1000;
  logic        m_cal = 1'b0, m_sample = 1'b0, m_sv = 1'b0;
  int          m_votes = 0;
  logic [1:0]  hist = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_t = 0; m_trim = 4'b1000; m_cal = 1'b0;
      m_sample = 1'b0; m_sv = 1'b0; m_votes = 0; hist = 2'b00;
    end else begin
      logic cs;
      int   pc;
      cs   = hist[1];
      hist = {hist[0], bus.cmp_in};
      m_sv = 1'b0;
      if (!bus.ena) begin
        m_mode = M_IDLE;
        if (bus.start_cal) m_cal = 1'b0;
      end else if (bus.start_cal && m_mode != M_CAL) begin
        m_mode = M_CAL; m_t = 0; m_trim = 4'b1000; m_cal = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_t = 0;
            if (m_cal) m_mode = M_RUN;
            else begin m_mode = M_CAL; m_trim = 4'b1000; end
          end
          M_CAL: begin
            if (m_t >= AZ && (m_t - AZ) % SET == SET - 1)
              m_trim[TW - 1 - (m_t - AZ) / SET] = cs;
            m_t++;
            if (m_t == AZ + TW * SET) begin
              m_mode = M_RUN; m_t = 0; m_cal = 1'b1;
            end else if (m_t >= AZ && (m_t - AZ) % SET == 0) begin
              m_trim[TW - 1 - (m_t - AZ) / SET] = 1'b1;
            end
          end
          default: begin
            pc = m_t % PER;
            if (pc == AZ + SET) m_votes = int'(cs);
            else if (pc > AZ + SET && pc < AZ + SET + VN) m_votes += int'(cs);
            if (pc == AZ + SET + VN) begin
              m_sample = (m_votes > VN / 2);
              m_sv = 1'b1;
            end
            m_t++;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      int pc;
      pc = m_t % PER;
      chk("ota_en", bus.ota_en, (m_mode == M_CAL) || (m_mode == M_RUN && pc <= AZ + SET + VN));
      chk("az_en", bus.az_en, (m_mode == M_CAL) || (m_mode == M_RUN && pc < AZ));
      chk("busy", bus.busy, m_mode != M_IDLE);
      chk("trim", bus.trim, m_trim);
      chk("cal_done", bus.cal_done, m_cal);
      chk("sample", bus.sample, m_sample);
      chk("sample_valid", bus.sample_valid, m_sv);
    end
  end

  function automatic logic cal_pat(input int mode, input int c);
    if (mode == 1) return 1'b1;
    if (mode == 2) return (c >= 8 && c < 12) || (c >= 16 && c < 20);
    return 1'b0;
  endfunction

  // Starts from IDLE with cal_done=0; returns cycle (after leaving IDLE) where cal_done is first seen.
  task automatic cal_from_idle(input int mode, output int rise);
    bus.ena = 1'b1;
    rise = -1;
    for (int c = -1; c < 40; c++) begin
      bus.cmp_in = cal_pat(mode, c);
      @(negedge clk);
      if (c == -1) chk("cal_entry_trim", bus.trim, 4'b1000);
      if (bus.cal_done && rise < 0) rise = c + 1;
    end
  endtask

  task automatic go_idle_clear();
    bus.ena = 1'b0;
    bus.start_cal = 1'b1;
    @(negedge clk);
    bus.start_cal = 1'b0;
    chk("idle_clear_cal_done", bus.cal_done, 0);
    chk("idle_clear_busy", bus.busy, 0);
  endtask

  task automatic wait_sv();
    int n = 0;
    while (!bus.sample_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_sample_valid", bus.sample_valid, 1);
  endtask

  // Drives cmp_in so cmp_s over the three vote cycles equals pat[2], pat[1], pat[0].
  task automatic vote(input logic [2:0] pat, input logic exp, input string nm);
    wait_sv();
    for (int k = 0; k < PER; k++) begin
      int pc;
      pc = (16 + k) % PER;
      if (pc == 10)      bus.cmp_in = pat[2];
      else if (pc == 11) bus.cmp_in = pat[1];
      else if (pc == 12) bus.cmp_in = pat[0];
      else               bus.cmp_in = 1'($urandom);
      @(negedge clk);
    end
    chk({nm, "_valid"}, bus.sample_valid, 1);
    chk(nm, bus.sample, exp);
  endtask

  initial begin
    int rise, cc, n_low, n_az, n_sv;
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rise, cc, n_low, n_az, n_sv;
    rst_n = 1'b1;
    bus.ena = 1'b0;
    bus.start_cal = 1'b0;
    bus.cmp_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trim", bus.trim, 4'b1000);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ota_en", bus.ota_en, 0);
    chk("rst_cal_done", bus.cal_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cal_from_idle(1, rise);
    chk("cal1_rise", rise, 24);
    chk("cal1_trim", bus.trim, 4'b1111);

    wait_sv();
    n_low = 0; n_az = 0; n_sv = 0;
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      if (!bus.ota_en) n_low++;
      if (bus.az_en) n_az++;
      if (bus.sample_valid) n_sv++;
    end
    chk("run_ota_low_cycles", n_low, 16);
    chk("run_az_cycles", n_az, 8);
    chk("run_sv_per_period", n_sv, 1);
    chk("run_sample_ones", bus.sample, 1);

    vote(3'b101, 1'b1, "vote_101");
    vote(3'b010, 1'b0, "vote_010");
    vote(3'b110, 1'b1, "vote_110");
    vote(3'b001, 1'b0, "vote_001");

    go_idle_clear();
    cal_from_idle(0, rise);
    chk("cal0_rise", rise, 24);
    chk("cal0_trim", bus.trim, 4'b0000);

    go_idle_clear();
    cal_from_idle(2, rise);
    chk("calwin_trim", bus.trim, 4'b1010);

    go_idle_clear();
    bus.ena = 1'b1;
    repeat (12) begin
      bus.cmp_in = 1'($urandom);
      @(negedge clk);
    end
    bus.ena = 1'b0;
    @(negedge clk);
    chk("drop_ota_en", bus.ota_en, 0);
    chk("drop_az_en", bus.az_en, 0);
    chk("drop_cal_done", bus.cal_done, 0);
    chk("drop_busy", bus.busy, 0);
    cal_from_idle(1, rise);
    chk("recal_rise", rise, 24);
    chk("recal_trim", bus.trim, 4'b1111);

    wait_sv();
    bus.start_cal = 1'b1;
    @(negedge clk);
    bus.start_cal = 1'b0;
    chk("runoff_cal_trim", bus.trim, 4'b1000);
    chk("runoff_cal_done", bus.cal_done, 0);
    chk("runoff_cal_az", bus.az_en, 1);
    cc = 0;
    repeat (11) begin @(negedge clk); cc++; end
    bus.start_cal = 1'b1;
    @(negedge clk);
    cc++;
    bus.start_cal = 1'b0;
    while (!bus.cal_done && cc < 60) begin @(negedge clk); cc++; end
    chk("calbit_startcal_ignored", cc, 24);

    for (int i = 0; i < 3000; i++) begin
      bus.ena       = ($urandom % 300) != 0;
      bus.start_cal = ($urandom % 200) == 0;
      bus.cmp_in    = 1'($urandom);
      @(negedge clk);
    end
    bus.start_cal = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
